// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory handshake, redirect input,
// decode handshake and immediate-extender controls.
interface instruction_fetch_unit_if;
  localparam int unsigned XLEN = 16;
  localparam int unsigned IMMW = 8;

  // Instruction memory side
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  // Branch/jump redirect
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  // Decode side
  logic            ir_valid;
  logic            ir_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;

  // Immediate extender controls
  logic [IMMW-1:0] imm;
  logic            ext_signed;

  // Fetch unit view
  modport master (
    output mem_req, mem_addr, ir_valid, instr, instr_pc, imm, ext_signed,
    input  mem_ack, mem_rdata, redirect_valid, redirect_pc, ir_ready
  );

  // Environment view (memory, branch unit, decode)
  modport slave (
    input  mem_req, mem_addr, ir_valid, instr, instr_pc, imm, ext_signed,
    output mem_ack, mem_rdata, redirect_valid, redirect_pc, ir_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches 16-bit words over a req/ack
// handshake into the IR, offers them to decode, and handles redirects.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC       = 16'h0000,
  parameter logic [15:0] SIGNED_OP_MASK = 16'h0000
) (
  input  logic                      CLK,
  input  logic                      Reset_n,
  input  logic                      run,
  instruction_fetch_unit_if.master  bus
);

  localparam int unsigned XLEN = 16;
  localparam int unsigned IMMW = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            ir_valid_q, ir_valid_d;

  // Where to go once the current fetch slot is finished
  state_e          resume_state_c;
  assign resume_state_c = run ? FETCH : IDLE;

  // State and datapath registers
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      instr_pc_q <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      instr_pc_q <= instr_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  // Next-state and datapath update; redirect outranks ack and ir_ready
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    instr_pc_d = instr_pc_q;
    ir_valid_d = ir_valid_q;

    unique case (state_q)
      IDLE: begin
        if (bus.redirect_valid) begin
          pc_d = bus.redirect_pc;
        end else if (run) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (bus.redirect_valid) begin
          pc_d = bus.redirect_pc;
          // Ack this cycle closes the transaction; otherwise it is still in flight
          state_d = bus.mem_ack ? resume_state_c : DISCARD;
        end else if (bus.mem_ack) begin
          ir_d       = bus.mem_rdata;
          instr_pc_d = pc_q;
          pc_d       = pc_q + XLEN'(1);
          ir_valid_d = 1'b1;
          state_d    = HOLD;
        end
      end

      HOLD: begin
        if (bus.redirect_valid) begin
          pc_d       = bus.redirect_pc;
          ir_valid_d = 1'b0;
          state_d    = resume_state_c;
        end else if (bus.ir_ready) begin
          ir_valid_d = 1'b0;
          state_d    = resume_state_c;
        end
      end

      DISCARD: begin
        if (bus.redirect_valid) begin
          pc_d = bus.redirect_pc;
        end
        // The stale response is dropped whenever it shows up, even alongside
        // a redirect, so the unit never waits for an ack that will not come
        if (bus.mem_ack) begin
          state_d = resume_state_c;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus outputs decoded from registers
  assign bus.mem_req    = (state_q == FETCH);
  assign bus.mem_addr   = pc_q;
  assign bus.ir_valid   = ir_valid_q;
  assign bus.instr      = ir_q;
  assign bus.instr_pc   = instr_pc_q;
  assign bus.imm        = ir_q[IMMW-1:0];
  assign bus.ext_signed = SIGNED_OP_MASK[ir_q[15:12]];

endmodule
